// File: rtl/ad5541_spi_stream.sv
// Streaming AD5541-class DAC writer: sample FIFO in, fixed-rate SPI frames out (sclk/mosi/cs).
// Optional macro AD5541_UNDERRUN_MIDSCALE_EN: an underrun sends midscale instead of repeating the last word.
module ad5541_spi_stream #(
  parameter int DATA_W        = 16,
  parameter int SCLK_HALF     = 1,
  parameter int CS_SETUP      = 1,
  parameter int SAMPLE_PERIOD = 200,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                          clk_10m,
  input  logic                          rst,
  input  logic                          i_enable,
  input  logic [DATA_W-1:0]             i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_underrun,
  output logic                          o_busy,
  output logic                          sclk,
  output logic                          mosi,
  output logic                          cs
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam int PW = $clog2(2 * SCLK_HALF + CS_SETUP + 1);
  localparam int BW = $clog2(DATA_W);
  localparam logic [TW-1:0] TICK_LAST  = TW'(SAMPLE_PERIOD - 1);
  localparam logic [PW-1:0] SETUP_LAST = PW'((CS_SETUP > 0) ? CS_SETUP - 1 : 0);
  localparam logic [PW-1:0] PH_LAST    = PW'(2 * SCLK_HALF - 1);
  localparam logic [PW-1:0] PH_HALF    = PW'(SCLK_HALF);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  if (SAMPLE_PERIOD < CS_SETUP + 2 * SCLK_HALF * DATA_W + 3) begin : g_period_check
    $error("ad5541_spi_stream: SAMPLE_PERIOD too short for one frame");
  end

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_SHIFT, S_END} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       tick_cnt_q;
  logic                tick;
  logic [PW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   last_q, last_d;
  logic                underrun_d, busy_d, sclk_d, mosi_d, cs_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q;
  logic                push, pop;

  // Counter held at 0 while disabled, so the enabling cycle is itself a tick.
  always_ff @(posedge clk_10m) begin
    if (rst || !i_enable)            tick_cnt_q <= '0;
    else if (tick_cnt_q == TICK_LAST) tick_cnt_q <= '0;
    else                             tick_cnt_q <= tick_cnt_q + 1'b1;
  end
  assign tick = i_enable && (tick_cnt_q == '0);

  assign o_ready = (level_q != LEVEL_FULL);
  assign o_level = level_q;
  assign push    = i_valid && o_ready;
  assign pop     = (state_q == S_LOAD) && (level_q != '0);

  always_ff @(posedge clk_10m) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_10m) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    last_d     = last_q;
    underrun_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (tick) state_d = S_LOAD;
      S_LOAD: begin
        if (level_q != '0) begin
          shreg_d = mem_q[rd_ptr_q];
          last_d  = mem_q[rd_ptr_q];
        end else begin
`ifdef AD5541_UNDERRUN_MIDSCALE_EN
          shreg_d = {1'b1, {(DATA_W-1){1'b0}}};
          last_d  = {1'b1, {(DATA_W-1){1'b0}}};
`else
          shreg_d = last_q;
`endif
          underrun_d = 1'b1;
        end
        cnt_d   = '0;
        bit_d   = '0;
        state_d = (CS_SETUP > 0) ? S_SETUP : S_SHIFT;
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == PH_LAST) begin
          cnt_d   = '0;
          shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
          if (bit_q == BIT_LAST) state_d = S_END;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pins are computed from next-state values so each register shows the new state's level.
  always_comb begin
    sclk_d = !((state_d == S_SHIFT) && (cnt_d < PH_HALF));
    mosi_d = (state_d == S_SHIFT) ? shreg_d[DATA_W-1] : 1'b1;
    cs_d   = !(state_d inside {S_SETUP, S_SHIFT, S_END});
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_10m) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      last_q     <= '0;
      o_underrun <= 1'b0;
      o_busy     <= 1'b0;
      sclk       <= 1'b1;
      mosi       <= 1'b1;
      cs         <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
      o_underrun <= underrun_d;
      o_busy     <= busy_d;
      sclk       <= sclk_d;
      mosi       <= mosi_d;
      cs         <= cs_d;
    end
  end
endmodule

// File: tb/tb_ad5541_spi_stream.sv
// Bench for ad5541_spi_stream: default instance plus a SCLK_HALF=3/CS_SETUP=2 instance.
module tb_ad5541_spi_stream;
  localparam int W = 16;

  logic clk = 1'b0;
  always #50 clk = ~clk;

  logic         rst, en, valid, ready, ur, busy, sclk, mosi, cs;
  logic [W-1:0] data;
  logic [4:0]   level;
  logic         en6, valid6, ready6, ur6, busy6, sclk6, mosi6, cs6;
  logic [W-1:0] data6;
  logic [4:0]   level6;

  ad5541_spi_stream dut (
    .clk_10m(clk), .rst(rst), .i_enable(en), .i_data(data), .i_valid(valid),
    .o_ready(ready), .o_level(level), .o_underrun(ur), .o_busy(busy),
    .sclk(sclk), .mosi(mosi), .cs(cs));

  ad5541_spi_stream #(.SCLK_HALF(3), .CS_SETUP(2)) dut6 (
    .clk_10m(clk), .rst(rst), .i_enable(en6), .i_data(data6), .i_valid(valid6),
    .o_ready(ready6), .o_level(level6), .o_underrun(ur6), .o_busy(busy6),
    .sclk(sclk6), .mosi(mosi6), .cs(cs6));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = 0;
  int frames_started = 0;
  logic [W-1:0] model_fifo[$];
  logic [W-1:0] last_word = '0;
  logic [W-1:0] exp_q[$];
  int           exp_ur_q[$];
  logic [W-1:0] cap_word_q[$];
  int cap_len_q[$], cap_gap_q[$], cap_falls_q[$], cap_bits_q[$];
  int cap_ur_q[$], cap_busy_q[$], cap_rise_q[$];
  int f6_done = 0, f6_low, f6_gap, f6_period, f6_bits, f6_busy, f6_ur;
  logic [W-1:0] f6_word;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Frame capture for the default instance: cs-low length, setup gap, sclk edges, mosi on rising sclk.
  initial begin : mon_a
    logic cs_p, sclk_p, in_fr;
    int low, gap, falls, bits, ur_acc, busy_run;
    logic [W-1:0] word;
    cs_p = 1'b1; sclk_p = 1'b1; in_fr = 1'b0;
    low = 0; gap = -1; falls = 0; bits = 0; ur_acc = 0; busy_run = 0; word = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_fr = 1'b0; ur_acc = 0; busy_run = 0;
      end else begin
        if (ur) ur_acc++;
        if (busy) busy_run++;
        if (!cs && cs_p) begin
          in_fr = 1'b1; low = 0; gap = -1; falls = 0; bits = 0; word = '0;
          frames_started++;
        end
        if (in_fr && !cs) begin
          low++;
          if (!sclk && sclk_p) begin
            if (falls == 0) gap = low - 1;
            falls++;
          end
          if (sclk && !sclk_p) begin
            word = {word[W-2:0], mosi};
            bits++;
          end
        end
        if (in_fr && cs && !cs_p) begin
          cap_word_q.push_back(word); cap_len_q.push_back(low); cap_gap_q.push_back(gap);
          cap_falls_q.push_back(falls); cap_bits_q.push_back(bits); cap_ur_q.push_back(ur_acc);
          cap_busy_q.push_back(busy_run); cap_rise_q.push_back(cyc);
          in_fr = 1'b0; ur_acc = 0; busy_run = 0;
        end
      end
      cs_p = cs; sclk_p = sclk;
    end
  end

  initial begin : mon_6
    logic cs_p, sclk_p, in_fr;
    int low, falls, bits, ur_acc, busy_run;
    logic [W-1:0] word;
    cs_p = 1'b1; sclk_p = 1'b1; in_fr = 1'b0;
    low = 0; falls = 0; bits = 0; ur_acc = 0; busy_run = 0; word = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ur6) ur_acc++;
        if (busy6) busy_run++;
        if (!cs6 && cs_p) begin
          in_fr = 1'b1; low = 0; falls = 0; bits = 0; word = '0;
        end
        if (in_fr && !cs6) begin
          low++;
          if (!sclk6 && sclk_p) begin
            if (falls == 0) f6_gap = low - 1;
            if (falls == 1) f6_period = (low - 1) - f6_gap;
            falls++;
          end
          if (sclk6 && !sclk_p) begin
            word = {word[W-2:0], mosi6};
            bits++;
          end
        end
        if (in_fr && cs6 && !cs_p) begin
          f6_low = low; f6_bits = bits; f6_word = word; f6_busy = busy_run; f6_ur = ur_acc;
          f6_done++;
          in_fr = 1'b0;
        end
      end
      cs_p = cs6; sclk_p = sclk6;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    valid = 1'b1;
    data  = w;
    @(posedge clk); #1;
    valid = 1'b0;
    model_fifo.push_back(w);
  endtask

  // One update tick: the oldest queued sample goes out, or the underrun word if none is queued.
  task automatic model_tick();
    if (model_fifo.size() > 0) begin
      last_word = model_fifo.pop_front();
      exp_ur_q.push_back(0);
    end else begin
`ifdef AD5541_UNDERRUN_MIDSCALE_EN
      last_word = 16'h8000;
`endif
      exp_ur_q.push_back(1);
    end
    exp_q.push_back(last_word);
  endtask

  task automatic check_next_frame(input bit spacing);
    int waited = 0;
    int rise;
    while (cap_word_q.size() == 0 && waited < 1000) begin
      @(posedge clk);
      waited++;
    end
    checks++;
    assert (cap_word_q.size() > 0) else begin
      errors++;
      $error("FAIL frame_timeout observed=no_frame expected=frame");
    end
    if (cap_word_q.size() > 0) begin
      chk("frame_word", cap_word_q.pop_front(), exp_q.pop_front());
      chk("frame_underrun_pulses", cap_ur_q.pop_front(), exp_ur_q.pop_front());
      chk("frame_cs_low", cap_len_q.pop_front(), 34);
      chk("frame_setup_gap", cap_gap_q.pop_front(), 1);
      chk("frame_sclk_falls", cap_falls_q.pop_front(), 16);
      chk("frame_sclk_rises", cap_bits_q.pop_front(), 16);
      chk("frame_busy_len", cap_busy_q.pop_front(), 35);
      rise = cap_rise_q.pop_front();
      if (spacing) chk("frame_spacing", rise - last_rise, 200);
      last_rise = rise;
    end
  endtask

  initial begin
    logic [W-1:0] w;
    int fs, waited;
    rst = 1'b1; en = 1'b0; valid = 1'b0; data = '0;
    en6 = 1'b0; valid6 = 1'b0; data6 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", cs, 1);
    chk("rst_sclk", sclk, 1);
    chk("rst_mosi", mosi, 1);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", ur, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", ready, 1);
    @(posedge clk); #1 rst = 1'b0;

    // Single word, frame starts from the enabling cycle
    push_word(16'hA5C3);
    @(negedge clk); chk("t1_level_push", level, 1);
    @(posedge clk); #1 en = 1'b1;
    model_tick();
    @(negedge clk); chk("t1_busy_enable_cycle", busy, 0);
    @(negedge clk); chk("t1_busy_load", busy, 1);
    @(negedge clk); chk("t1_level_pop", level, 0);
    chk("t1_cs_low", cs, 0);

    // Three words on consecutive ticks, then an underrun repeating 0x1234
    @(posedge clk); #1;
    w = W'($urandom); push_word(w);
    w = W'($urandom); push_word(w);
    push_word(16'h1234);
    @(negedge clk); chk("t2_level3", level, 3);
    repeat (4) model_tick();
    check_next_frame(1'b0);
    repeat (4) check_next_frame(1'b1);
    @(posedge clk); #1 en = 1'b0;

    // Fill to full with i_valid held, then pops with and without a simultaneous push
    @(posedge clk); #1 valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data = W'($urandom);
      if (model_fifo.size() < 16) model_fifo.push_back(data);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    @(negedge clk);
    chk("t4_level_full", level, 16);
    chk("t4_ready_full", ready, 0);
    @(posedge clk); #1 en = 1'b1;
    model_tick();
    @(posedge clk); #1 en = 1'b0; valid = 1'b1; data = W'($urandom);
    @(negedge clk);
    chk("t4_level_load_full", level, 16);
    chk("t4_ready_load_full", ready, 0);
    @(posedge clk); #1 valid = 1'b0;
    @(negedge clk); chk("t4_level_after_pop", level, 15);
    check_next_frame(1'b0);
    @(posedge clk); #1 en = 1'b1;
    model_tick();
    @(posedge clk); #1 en = 1'b0; valid = 1'b1; data = W'($urandom);
    model_fifo.push_back(data);
    @(negedge clk); chk("t4_ready_load", ready, 1);
    @(posedge clk); #1 valid = 1'b0;
    @(negedge clk); chk("t4_level_push_pop", level, 15);
    check_next_frame(1'b0);

    // Reset during SHIFT bit 7 aborts the frame
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 en = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    @(negedge clk); chk("t5_cs_in_frame", cs, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_cs", cs, 1);
    chk("t5_sclk", sclk, 1);
    chk("t5_mosi", mosi, 1);
    chk("t5_level", level, 0);
    chk("t5_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    model_fifo.delete();
    last_word = '0;
    fs = frames_started;
    repeat (300) @(posedge clk);
    chk("t5_no_frames", frames_started, fs);
    chk("t5_no_capture", cap_word_q.size(), 0);
    @(posedge clk); #1 en = 1'b1;
    model_tick();
    @(posedge clk); #1 en = 1'b0;
    check_next_frame(1'b0);

    // Slow-sclk instance
    @(posedge clk); #1 valid6 = 1'b1; data6 = W'($urandom); w = data6;
    @(posedge clk); #1 valid6 = 1'b0;
    @(negedge clk); chk("t6_level_push", level6, 1);
    @(posedge clk); #1 en6 = 1'b1;
    @(posedge clk); #1 en6 = 1'b0;
    waited = 0;
    while (f6_done == 0 && waited < 400) begin
      @(posedge clk);
      waited++;
    end
    chk("t6_frame_seen", f6_done, 1);
    chk("t6_word", f6_word, w);
    chk("t6_cs_low", f6_low, 99);
    chk("t6_setup_gap", f6_gap, 2);
    chk("t6_sclk_period", f6_period, 6);
    chk("t6_sclk_rises", f6_bits, 16);
    chk("t6_busy_len", f6_busy, 100);
    chk("t6_underrun", f6_ur, 0);
    chk("t6_ready", ready6, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
